// File: rtl/adder_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_sched_pkg
// Description : Shared constants and types for the round-robin adder
//               scheduler: operand/statistic widths, the per-requester
//               packing slice width and the scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_sched_pkg;

  localparam int DATA_W  = 64;
  localparam int STAT_W  = 32;
  // Width of one requester's slice in the packed req_a / req_b buses.
  localparam int SLICE_W = DATA_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder_64bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_64bit
// Description : 64-bit binary adder with carry-in, carry-out and two's
//               complement signed overflow flag.
// Ports       : a, b     - operands (64)
//               cin      - carry-in
//               sum      - a + b + cin (64)
//               cout     - unsigned carry-out
//               overflow - signed overflow of the 64-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_64bit
  import adder_sched_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              overflow
);

  logic [DATA_W:0] w_full;

  assign w_full   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  assign sum      = w_full[DATA_W-1:0];
  assign cout     = w_full[DATA_W];
  // Overflow: operands share a sign that the result does not.
  assign overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. The search begins at ptr
//               and wraps, so the requester at ptr has top priority.
// Ports       : req   - request vector (NUM_REQ)
//               ptr   - index with highest priority (ID_W)
//               grant - one-hot grant, all-zero when no request
//               idx   - encoded index of the granted requester
//               any   - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int w_cand;

  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // ptr is always below NUM_REQ, so one modulo is enough to wrap.
      w_cand = (int'(ptr) + off) % NUM_REQ;
      if (!any && req[w_cand]) begin
        any           = 1'b1;
        grant[w_cand] = 1'b1;
        idx           = ID_W'(w_cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adder_rr_scheduler
// Description : Shares one 64-bit adder among NUM_REQ requesters with
//               round-robin arbitration. Multi-beat operations lock the
//               grant until the last beat and chain carry between beats.
//               Results leave through one registered response channel.
// Ports       : clk, rst_n (async, active-low)
//               req_valid/req_ready/req_a/req_b/req_cin/req_last - per
//                 requester beat channel, operands packed 64 bits each
//               rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout/
//                 rsp_overflow/rsp_last - response channel
//               stat_ops - per-requester completed-operation counters,
//                 present only when ADDER_SCHED_STATS_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*SLICE_W-1:0] req_a,
  input  logic [NUM_REQ*SLICE_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_cout,
  output logic                      rsp_overflow,
  output logic                      rsp_last
`ifdef ADDER_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_ops
`endif
);

  localparam logic [NUM_REQ-1:0] c_one     = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    c_last_id = ID_W'(NUM_REQ - 1);

  state_t              r_state, w_state_next;
  logic [ID_W-1:0]     r_lock_id, w_lock_id_next;
  logic [ID_W-1:0]     r_ptr, w_ptr_next;
  logic                r_carry;

  logic [NUM_REQ-1:0]  w_pick_grant;
  logic [ID_W-1:0]     w_pick_idx;
  logic                w_pick_any;

  logic [NUM_REQ-1:0]  w_gnt_onehot;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [ID_W-1:0]     w_gnt_inc;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_last;

  logic [DATA_W-1:0]   w_a, w_b, w_sum;
  logic                w_cin, w_cout, w_ovf;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_pick_grant),
    .idx   (w_pick_idx),
    .any   (w_pick_any)
  );

  // The response register can take a new beat when empty or draining.
  assign w_slot_free = !rsp_valid || rsp_ready;

  // In LOCK the grant ignores the arbiter so no other requester can
  // slip in mid-burst, even while the owner has valid low.
  assign w_gnt_idx    = (r_state == LOCK) ? r_lock_id : w_pick_idx;
  assign w_gnt_onehot = (r_state == LOCK) ? (c_one << r_lock_id) : w_pick_grant;
  assign req_ready    = w_slot_free ? w_gnt_onehot : '0;
  assign w_accept     = |(req_valid & req_ready);

  assign w_a       = req_a[SLICE_W*w_gnt_idx +: SLICE_W];
  assign w_b       = req_b[SLICE_W*w_gnt_idx +: SLICE_W];
  assign w_last    = req_last[w_gnt_idx];
  // First beat takes the requester's carry-in; later beats chain carry.
  assign w_cin     = (r_state == LOCK) ? r_carry : req_cin[w_gnt_idx];
  assign w_gnt_inc = (w_gnt_idx == c_last_id) ? '0 : w_gnt_idx + 1'b1;

  full_adder_64bit u_add (
    .a        (w_a),
    .b        (w_b),
    .cin      (w_cin),
    .sum      (w_sum),
    .cout     (w_cout),
    .overflow (w_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lock_id <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_lock_id <= w_lock_id_next;
      r_ptr     <= w_ptr_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next   = r_state;
    w_lock_id_next = r_lock_id;
    w_ptr_next     = r_ptr;
    if (w_accept) begin
      if (w_last) begin
        w_state_next = IDLE;
        w_ptr_next   = w_gnt_inc;
      end else begin
        w_state_next   = LOCK;
        w_lock_id_next = w_gnt_idx;
      end
    end
  end

  // Response register and carry chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_last     <= 1'b0;
      r_carry      <= 1'b0;
    end else if (w_accept) begin
      rsp_valid    <= 1'b1;
      rsp_id       <= w_gnt_idx;
      rsp_sum      <= w_sum;
      rsp_cout     <= w_cout;
      rsp_overflow <= w_ovf;
      rsp_last     <= w_last;
      r_carry      <= w_cout;
    end else if (rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

`ifdef ADDER_SCHED_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    logic [STAT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_accept && w_last && (w_gnt_idx == ID_W'(gi)) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign stat_ops[STAT_W*gi +: STAT_W] = r_cnt;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_rr_scheduler
// Description : Directed self-checking bench for adder_rr_scheduler with
//               NUM_REQ=4. Inputs change 1 time unit after the rising edge;
//               outputs are checked at that point or later in the cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_rr_scheduler;

  localparam int NR = 4;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*64-1:0] req_a;
  logic [NR*64-1:0] req_b;
  logic [NR-1:0]   req_cin;
  logic [NR-1:0]   req_last;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [63:0]     rsp_sum;
  logic            rsp_cout;
  logic            rsp_overflow;
  logic            rsp_last;
`ifdef ADDER_SCHED_STATS_EN
  logic [NR*32-1:0] stat_ops;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  adder_rr_scheduler #(.NUM_REQ(NR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .req_last     (req_last),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_cout     (rsp_cout),
    .rsp_overflow (rsp_overflow),
    .rsp_last     (rsp_last)
`ifdef ADDER_SCHED_STATS_EN
    ,
    .stat_ops     (stat_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic last);
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    req_cin[i]        = cin;
    req_last[i]       = last;
    req_valid[i]      = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_last  = '0;
    rsp_ready = 1'b1;
    repeat (2) tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", rsp_id); else n_pass++;
    n_checks++; if (rsp_sum !== 64'h0) $display("FAIL reset_sum: got %h want 0", rsp_sum); else n_pass++;
    n_checks++; if ({rsp_cout, rsp_overflow, rsp_last} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {rsp_cout, rsp_overflow, rsp_last}); else n_pass++;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_sum !== 64'h0) $display("FAIL single_sum: got %h want 0", rsp_sum); else n_pass++;
    n_checks++; if ({rsp_cout, rsp_overflow, rsp_last} !== 3'b101)
      $display("FAIL single_flags: got %b want 101", {rsp_cout, rsp_overflow, rsp_last}); else n_pass++;
    n_checks++; if (rsp_id !== 2'd0) $display("FAIL single_id: got %0d want 0", rsp_id); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    // Pointer is now 1, so requester 1 is served.
    set_req(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1);
    tick();
    req_valid = '0;
    n_checks++; if (rsp_sum !== 64'h8000_0000_0000_0000) $display("FAIL ovf_sum: got %h want 8000000000000000", rsp_sum); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_cout, rsp_overflow} !== 3'b101)
      $display("FAIL ovf_flags: got %b want 101", {rsp_valid, rsp_cout, rsp_overflow}); else n_pass++;
    n_checks++; if (rsp_id !== 2'd1) $display("FAIL ovf_id: got %0d want 1", rsp_id); else n_pass++;
    tick();
  endtask

  task automatic test_two_beat();
    // Pointer is 2: requester 2 wins over requester 1.
    set_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    set_req(1, 64'd5, 64'd6, 1'b0, 1'b1);
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL tb_beat0_ready: got %b want 0100", req_ready); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last} !== {1'b1, 2'd2, 64'h0, 1'b1, 1'b0})
      $display("FAIL tb_beat0_rsp: got v%b id%0d sum%h c%b l%b want v1 id2 sum0 c1 l0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last); else n_pass++;
    // Owner stalls for one cycle: grant must stay on requester 2.
    req_valid[2] = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL tb_stall_ready: got %b want 0100", req_ready); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL tb_stall_valid: got %b want 0", rsp_valid); else n_pass++;
    set_req(2, 64'h0, 64'h0, 1'b0, 1'b1);
    tick();
    req_valid[2] = 1'b0;
    n_checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last} !== {1'b1, 2'd2, 64'h1, 1'b0, 1'b1})
      $display("FAIL tb_beat1_rsp: got v%b id%0d sum%h c%b l%b want v1 id2 sum1 c0 l1",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last); else n_pass++;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL tb_req1_ready: got %b want 0010", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    n_checks++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd1, 64'd11})
      $display("FAIL tb_req1_rsp: got v%b id%0d sum%0d want v1 id1 sum11", rsp_valid, rsp_id, rsp_sum); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    // Pointer is 2; only requester 0 is valid.
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    tick();
    req_valid = '0;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL rmb_beat0_valid: got %b want 1", rsp_valid); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rmb_async_clear: got %b want 0", rsp_valid); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    set_req(3, 64'd5, 64'd6, 1'b0, 1'b1);
    #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL rmb_ready: got %b want 1000", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    n_checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_last} !== {1'b1, 2'd3, 64'd11, 1'b1})
      $display("FAIL rmb_rsp: got v%b id%0d sum%0d l%b want v1 id3 sum11 l1",
               rsp_valid, rsp_id, rsp_sum, rsp_last); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    // Pointer is 0 after requester 3 completed.
    for (int i = 0; i < NR; i++) set_req(i, 64'h100 * (i + 1), 64'(i), 1'b0, 1'b1);
    #1;
    for (int k = 0; k < 8; k++) begin
      int e;
      logic [NR-1:0] exp_rdy;
      e = k % NR;
      exp_rdy = 4'b0001 << e;
      n_checks++; if (req_ready !== exp_rdy) $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); else n_pass++;
      tick();
      n_checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'(e)})
        $display("FAIL rr_id[%0d]: got v%b id%0d want v1 id%0d", k, rsp_valid, rsp_id, e); else n_pass++;
      n_checks++; if (rsp_sum !== 64'h100 * (e + 1) + 64'(e))
        $display("FAIL rr_sum[%0d]: got %h want %h", k, rsp_sum, 64'h100 * (e + 1) + 64'(e)); else n_pass++;
    end
    req_valid = '0;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rr_drain: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    set_req(0, 64'd1, 64'd2, 1'b0, 1'b1);
    set_req(1, 64'd3, 64'd4, 1'b0, 1'b1);
    tick();
    req_valid[0] = 1'b0;
    rsp_ready    = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_ready0: got %b want 0000", req_ready); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_last} !== {1'b1, 2'd0, 64'd3, 1'b1})
        $display("FAIL bp_hold[%0d]: got v%b id%0d sum%0d want v1 id0 sum3", k, rsp_valid, rsp_id, rsp_sum); else n_pass++;
      n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready); else n_pass++;
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL bp_resume_ready: got %b want 0010", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    n_checks++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd1, 64'd7})
      $display("FAIL bp_next: got v%b id%0d sum%0d want v1 id1 sum7", rsp_valid, rsp_id, rsp_sum); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", rsp_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_overflow();
    test_two_beat();
    test_reset_mid_burst();
    test_round_robin();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
